serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_slice.sv | 17 +
 rtl/serial_adder.sv | 167 ++++++++++++++++
 tb/tb_serial_adder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and counter sizing.
package adder_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Digit counter width: enough bits to hold N-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple slice: {cout, sum} = a + b + cin.
module adder_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Plain sum of one digit plus the incoming carry.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: adds WIDTH-bit operands DIGIT bits per clock, LSB digit first.
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN adds the overflow_out port
// (two's-complement overflow, registered alongside sum_out).
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             busy_out,
  output logic             done_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow_out
`else
  // overflow tracking not built in this configuration
`endif
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = cnt_width(N);

  // Refuse to build when the operand does not split into whole digits.
  if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  logic [ST_W-1:0]  state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             carry_r, carry_nxt;
  logic [WIDTH-1:0] a_r, a_nxt;
  logic [WIDTH-1:0] b_r, b_nxt;
  logic [WIDTH-1:0] acc_r, acc_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  logic [DIGIT-1:0]       slice_sum;
  logic                   slice_cout;
  logic [WIDTH+DIGIT-1:0] acc_wide;
  logic [WIDTH-1:0]       acc_shift;
  logic                   last_digit;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_nxt;
  logic msb_cin;
`else
  // no overflow state
`endif

  // One digit of the addition; operands are shifted so the active digit is always at bit 0.
  adder_slice #(.W(DIGIT)) u_slice (
    .a    (a_r[DIGIT-1:0]),
    .b    (b_r[DIGIT-1:0]),
    .cin  (carry_r),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New digit enters at the top of the accumulator; after N digits it lines up with bit 0.
  always_comb begin
    acc_wide   = {slice_sum, acc_r};
    acc_shift  = acc_wide[WIDTH+DIGIT-1:DIGIT];
    last_digit = (cnt_r == CNT_W'(N - 1));
  end

  // State register and all registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      carry_r   <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      acc_r     <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow_out <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      carry_r   <= carry_nxt;
      a_r       <= a_nxt;
      b_r       <= b_nxt;
      acc_r     <= acc_nxt;
      sum_out   <= sum_nxt;
      carry_out <= cout_nxt;
      busy_out  <= busy_nxt;
      done_out  <= done_nxt;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow_out <= ovf_nxt;
`endif
    end
  end

  // Next-state and next-output logic; results are only published on the final digit.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    carry_nxt = carry_r;
    a_nxt     = a_r;
    b_nxt     = b_r;
    acc_nxt   = acc_r;
    sum_nxt   = sum_out;
    cout_nxt  = carry_out;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    msb_cin = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ slice_sum[DIGIT-1];
    ovf_nxt = overflow_out;
`endif

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          a_nxt     = a_in;
          b_nxt     = b_in;
          carry_nxt = c_in;
          cnt_nxt   = '0;
          acc_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_RUN: begin
        a_nxt     = a_r >> DIGIT;
        b_nxt     = b_r >> DIGIT;
        carry_nxt = slice_cout;
        acc_nxt   = acc_shift;
        if (last_digit) begin
          cnt_nxt   = '0;
          sum_nxt   = acc_shift;
          cout_nxt  = slice_cout;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          ovf_nxt   = msb_cin ^ slice_cout;
`endif
        end else begin
          cnt_nxt  = cnt_r + CNT_W'(1);
          busy_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed scenarios on a 16/4 instance plus a randomized
// sweep over several (WIDTH, DIGIT) configurations, all checked through scoreboards.
module tb_serial_adder;

  localparam int unsigned DW = 16;
  localparam int unsigned DD = 4;
  localparam int unsigned DN = DW / DD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: exact integer sum truncated to w+1 bits.
  function automatic longint ref_total(input int unsigned w, input longint a,
                                       input longint b, input longint c);
    return (a + b + c) % (longint'(1) << (w + 1));
  endfunction

  // Reference: signed interpretation of the operands, overflow if out of range.
  function automatic bit ref_ovf(input int unsigned w, input longint a,
                                 input longint b, input longint c);
    longint half, sa, sb, s;
    half = longint'(1) << (w - 1);
    sa = (a >= half) ? a - 2 * half : a;
    sb = (b >= half) ? b - 2 * half : b;
    s  = sa + sb + c;
    return (s > half - 1) || (s < -half);
  endfunction

  function automatic int unsigned cfg_w(input int i);
    case (i)
      0: return 16;
      1: return 8;
      2: return 8;
      default: return 12;
    endcase
  endfunction

  function automatic int unsigned cfg_d(input int i);
    case (i)
      0: return 4;
      1: return 1;
      2: return 8;
      default: return 3;
    endcase
  endfunction

  // ---------------- directed instance ----------------
  logic          rst_n, start, c;
  logic [DW-1:0] a, b, sum;
  logic          cout, busy, done;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic          ovf;
`endif

  serial_adder #(.WIDTH(DW), .DIGIT(DD)) u_dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .start_in  (start),
    .a_in      (a),
    .b_in      (b),
    .c_in      (c),
    .sum_out   (sum),
    .carry_out (cout),
    .busy_out  (busy),
    .done_out  (done)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow_out (ovf)
`endif
  );

  typedef struct {
    logic [DW-1:0] s;
    logic          co;
    logic          ov;
    int            acc;
  } dexp_t;

  dexp_t dq[$];

  task automatic issue(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                       input logic tc, input logic [DW-1:0] es,
                       input logic ec, input logic eo);
    start = 1'b1;
    a = ta;
    b = tb;
    c = tc;
    dq.push_back('{s: es, co: ec, ov: eo, acc: cyc + 1});
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("d_done_seen", 64'(done), 64'd1);
  endtask

  // Directed scoreboard monitor.
  always @(negedge clk) begin : d_mon
    dexp_t e;
    if (done) begin
      chk("d_pending", 64'(dq.size() > 0), 64'd1);
      if (dq.size() > 0) begin
        e = dq.pop_front();
        chk("d_sum", 64'(sum), 64'(e.s));
        chk("d_carry", 64'(cout), 64'(e.co));
        chk("d_latency", 64'(cyc - e.acc), 64'(DN));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("d_ovf", 64'(ovf), 64'(e.ov));
`endif
      end
    end
  end

  // ---------------- randomized sweep ----------------
  for (genvar g = 0; g < 4; g++) begin : swp
    localparam int unsigned W = cfg_w(g);
    localparam int unsigned D = cfg_d(g);
    localparam int unsigned N = W / D;

    logic         rst_n_s, start_s, c_s;
    logic [W-1:0] a_s, b_s, sum_s;
    logic         cout_s, busy_s, done_s;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         ovf_s;
`endif
    bit           fin = 1'b0;
    longint       tq[$];
    bit           oq[$];
    int           aq[$];

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk_in    (clk),
      .rst_n_in  (rst_n_s),
      .start_in  (start_s),
      .a_in      (a_s),
      .b_in      (b_s),
      .c_in      (c_s),
      .sum_out   (sum_s),
      .carry_out (cout_s),
      .busy_out  (busy_s),
      .done_out  (done_s)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ,
      .overflow_out (ovf_s)
`endif
    );

    initial begin : drv
      int gap;
      rst_n_s = 1'b0;
      start_s = 1'b0;
      a_s = '0;
      b_s = '0;
      c_s = 1'b0;
      @(negedge clk);
      rst_n_s = 1'b1;
      for (int op = 0; op < 1000; op++) begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin
          start_s = 1'b0;
          a_s = W'($urandom);
          b_s = W'($urandom);
          c_s = 1'($urandom);
          @(negedge clk);
        end
        start_s = 1'b1;
        a_s = W'($urandom);
        b_s = W'($urandom);
        c_s = 1'($urandom);
        tq.push_back(ref_total(W, longint'(a_s), longint'(b_s), longint'(c_s)));
        oq.push_back(ref_ovf(W, longint'(a_s), longint'(b_s), longint'(c_s)));
        aq.push_back(cyc + 1);
        // Inputs are scrambled (including start) while the operation runs.
        repeat (N) begin
          @(negedge clk);
          start_s = 1'($urandom);
          a_s = W'($urandom);
          b_s = W'($urandom);
          c_s = 1'($urandom);
        end
        @(negedge clk);
      end
      start_s = 1'b0;
      repeat (N + 4) @(negedge clk);
      chk($sformatf("w%0dd%0d_drain", W, D), 64'(tq.size()), 64'd0);
      fin = 1'b1;
    end

    always @(negedge clk) begin : mon
      longint t;
      int     a0;
      bit     o;
      if (done_s) begin
        chk($sformatf("w%0dd%0d_pending", W, D), 64'(tq.size() > 0), 64'd1);
        if (tq.size() > 0) begin
          t  = tq.pop_front();
          o  = oq.pop_front();
          a0 = aq.pop_front();
          chk($sformatf("w%0dd%0d_sum", W, D), 64'(sum_s),
              64'(t) & ((64'd1 << W) - 64'd1));
          chk($sformatf("w%0dd%0d_carry", W, D), 64'(cout_s), 64'((t >> W) & 64'd1));
          chk($sformatf("w%0dd%0d_latency", W, D), 64'(cyc - a0), 64'(N));
`ifdef SERIAL_ADDER_OVERFLOW_EN
          chk($sformatf("w%0dd%0d_ovf", W, D), 64'(ovf_s), 64'(o));
`endif
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int t1;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    c = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", 64'(cout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // First start right after release, with exact busy/done timing.
    rst_n = 1'b1;
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(DN); i++) begin
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    chk("fin_busy", 64'(busy), 64'd0);
    chk("fin_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("done_pulse_width", 64'(done), 64'd0);

    issue(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    @(negedge clk);
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done(20);

    // Start and operand changes during RUN are ignored.
    @(negedge clk);
    issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a = 16'hAAAA;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    repeat (DN + 2) begin
      @(negedge clk);
      chk("ignored_start_busy", 64'(busy), 64'd0);
    end

    // Back-to-back: start held through DONE.
    issue(16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h1000;
    b = 16'h0200;
    c = 1'b1;
    wait_done(20);
    t1 = cyc;
    dq.push_back('{s: 16'h1201, co: 1'b0, ov: 1'b0, acc: cyc + 1});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      chk("b2b_hold_sum", 64'(sum), 64'h0303);
      @(negedge clk);
    end
    chk("b2b_done_seen", 64'(done), 64'd1);
    chk("b2b_gap", 64'(cyc - t1), 64'd5);

    // Reset two edges into RUN aborts the operation.
    @(negedge clk);
    start = 1'b1;
    a = 16'h8000;
    b = 16'h8000;
    c = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_carry", 64'(cout), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DN + 3) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);
    end
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    @(negedge clk);
    chk("d_drain", 64'(dq.size()), 64'd0);

    for (int i = 0; i < 20000; i++) begin
      if (swp[0].fin && swp[1].fin && swp[2].fin && swp[3].fin) break;
      @(negedge clk);
    end
    chk("sweep_complete",
        64'(swp[0].fin && swp[1].fin && swp[2].fin && swp[3].fin), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
